op_fetch_decode: RTL and testbench

Instruction front end for the matrix execution engine. Walks the 16-entry operation memory (Op_Mem) from address 0, fetches each 32-bit opcode with an enable/flag handshake, decodes it into unit-select and address fields, and hands one decoded instruction at a time to the execution engine over a valid/ready handshake. Fetch stops on a STOP opcode, an illegal opcode, a memory timeout, or the end of operation memory.

---
 rtl/mat_pkg.sv | 33 +++
 rtl/op_fetch_decode_if.sv | 27 ++
 rtl/op_decode.sv | 41 ++++
 rtl/op_fetch_decode.sv | 140 ++++++++++++++
 tb/tb_op_fetch_decode.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the matrix engine front end: opcodes, unit encoding,
// fetch FSM state codes and opcode field positions.
package mat_pkg;

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_SUB  = 8'h01;
    localparam logic [7:0] OP_MULT = 8'h10;
    localparam logic [7:0] OP_TRAN = 8'h20;
    localparam logic [7:0] OP_STOP = 8'hFF;

    typedef enum logic [1:0] {
        UNIT_AS   = 2'd0,
        UNIT_MULT = 2'd1,
        UNIT_TRAN = 2'd2,
        UNIT_RSVD = 2'd3
    } unit_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 24;
    localparam int DEST_MSB = 23;
    localparam int DEST_LSB = 16;
    localparam int SRC1_MSB = 15;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_MSB = 7;
    localparam int SRC2_LSB = 0;

endpackage

// File: rtl/op_fetch_decode_if.sv
// Bus bundles of the front end: the operation-memory read port and the
// decoded-instruction handshake towards the execution engine.
interface op_mem_if #(parameter int ADDR_W = 4);
    logic [ADDR_W-1:0] opCounter;
    logic              opEN;
    logic              opRW;
    logic [31:0]       fromOpBus;
    logic              opFleg;

    modport master (output opCounter, opEN, opRW, input fromOpBus, opFleg);
    modport slave  (input opCounter, opEN, opRW, output fromOpBus, opFleg);
endinterface

interface inst_if;
    logic       instValid;
    logic       instReady;
    logic [1:0] instUnit;
    logic       add1sub0;
    logic [7:0] instDest;
    logic [7:0] instSrc1;
    logic [7:0] instSrc2;

    modport master (output instValid, instUnit, add1sub0, instDest, instSrc1, instSrc2,
                    input instReady);
    modport slave  (input instValid, instUnit, add1sub0, instDest, instSrc1, instSrc2,
                    output instReady);
endinterface

// File: rtl/op_decode.sv
// Combinational opcode decoder: splits a 32-bit Op_Mem word into unit select,
// add/sub flag, address fields and STOP/illegal indications.
module op_decode
    import mat_pkg::*;
(
    input  logic [31:0] word,
    output unit_t       unit,
    output logic        add1sub0,
    output logic [7:0]  dest,
    output logic [7:0]  src1,
    output logic [7:0]  src2,
    output logic        is_stop,
    output logic        is_illegal
);

    logic [7:0] op;

    assign op   = word[OP_MSB:OP_LSB];
    assign dest = word[DEST_MSB:DEST_LSB];
    assign src1 = word[SRC1_MSB:SRC1_LSB];
    assign src2 = word[SRC2_MSB:SRC2_LSB];

    always_comb begin
        unit       = UNIT_RSVD;
        add1sub0   = 1'b0;
        is_stop    = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_ADD: begin
                unit     = UNIT_AS;
                add1sub0 = 1'b1;
            end
            OP_SUB:  unit = UNIT_AS;
            OP_MULT: unit = UNIT_MULT;
            OP_TRAN: unit = UNIT_TRAN;
            OP_STOP: is_stop = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/op_fetch_decode.sv
// Instruction front end: walks Op_Mem from address 0, fetches and decodes each
// opcode, and presents one instruction at a time on a valid/ready handshake.
module op_fetch_decode
    import mat_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      RESET,
    input  logic      start,
    op_mem_if.master  mem,
    inst_if.master    inst,
    output logic      busy,
    output logic      halted,
    output logic      illegal,
    output logic      timeout
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] A_LAST = {ADDR_W{1'b1}};

    logic [2:0]        state;
    logic [ADDR_W-1:0] op_counter;
    logic [TW-1:0]     wait_cnt;
    logic [1:0]        unit_q;
    logic              add1sub0_q;
    logic [7:0]        dest_q;
    logic [7:0]        src1_q;
    logic [7:0]        src2_q;
    logic              illegal_q;
    logic              timeout_q;

    unit_t      dec_unit;
    logic       dec_add1sub0;
    logic [7:0] dec_dest;
    logic [7:0] dec_src1;
    logic [7:0] dec_src2;
    logic       dec_stop;
    logic       dec_illegal;

    op_decode u_decode (
        .word       (mem.fromOpBus),
        .unit       (dec_unit),
        .add1sub0   (dec_add1sub0),
        .dest       (dec_dest),
        .src1       (dec_src1),
        .src2       (dec_src2),
        .is_stop    (dec_stop),
        .is_illegal (dec_illegal)
    );

    assign mem.opCounter  = op_counter;
    assign mem.opEN       = (state == ST_REQ);
    assign mem.opRW       = 1'b1;

    assign inst.instValid = (state == ST_HOLD);
    assign inst.instUnit  = unit_q;
    assign inst.add1sub0  = add1sub0_q;
    assign inst.instDest  = dest_q;
    assign inst.instSrc1  = src1_q;
    assign inst.instSrc2  = src2_q;

    assign busy    = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_HOLD);
    assign halted  = (state == ST_HALT);
    assign illegal = illegal_q;
    assign timeout = timeout_q;

    // Decoded fields are only loaded on WAIT->HOLD so they stay stable while stalled.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= ST_IDLE;
            op_counter <= '0;
            wait_cnt   <= '0;
            unit_q     <= 2'd0;
            add1sub0_q <= 1'b0;
            dest_q     <= 8'd0;
            src1_q     <= 8'd0;
            src2_q     <= 8'd0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_counter <= '0;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem.opFleg) begin
                        if (dec_stop) begin
                            state <= ST_HALT;
                        end else if (dec_illegal) begin
                            illegal_q <= 1'b1;
                            state     <= ST_HALT;
                        end else begin
                            unit_q     <= dec_unit;
                            add1sub0_q <= dec_add1sub0;
                            dest_q     <= dec_dest;
                            src1_q     <= dec_src1;
                            src2_q     <= dec_src2;
                            state      <= ST_HOLD;
                        end
                    end else if (wait_cnt == T_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= ST_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (inst.instReady) begin
                        if (op_counter == A_LAST) begin
                            state <= ST_HALT;
                        end else begin
                            op_counter <= op_counter + 1'b1;
                            state      <= ST_REQ;
                        end
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        illegal_q  <= 1'b0;
                        timeout_q  <= 1'b0;
                        op_counter <= '0;
                        state      <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_fetch_decode.sv
// Directed self-checking bench for op_fetch_decode with a one-cycle-latency
// Op_Mem model driving opFleg/fromOpBus.
module tb_op_fetch_decode;

    logic clk = 1'b0;
    logic RESET;
    logic start;
    logic busy, halted, illegal, timeout;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] prog [16];
    logic        mem_on    = 1'b0;
    logic        pend      = 1'b0;
    logic [3:0]  pend_addr = 4'd0;

    op_mem_if #(.ADDR_W(4)) mem_bus ();
    inst_if                 inst_bus ();

    op_fetch_decode #(.ADDR_W(4), .TIMEOUT(16)) dut (
        .clk     (clk),
        .RESET   (RESET),
        .start   (start),
        .mem     (mem_bus),
        .inst    (inst_bus),
        .busy    (busy),
        .halted  (halted),
        .illegal (illegal),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Op_Mem answers one cycle after it sees opEN.
    always @(posedge clk) begin
        #1;
        mem_bus.opFleg    = pend;
        mem_bus.fromOpBus = pend ? prog[pend_addr] : 32'hDEAD_BEEF;
        pend              = mem_on && mem_bus.opEN;
        pend_addr         = mem_bus.opCounter;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cnt"},   32'(mem_bus.opCounter), 32'd0);
        check({tag, "_en"},    32'(mem_bus.opEN), 32'd0);
        check({tag, "_rw"},    32'(mem_bus.opRW), 32'd1);
        check({tag, "_valid"}, 32'(inst_bus.instValid), 32'd0);
        check({tag, "_unit"},  32'(inst_bus.instUnit), 32'd0);
        check({tag, "_as"},    32'(inst_bus.add1sub0), 32'd0);
        check({tag, "_dest"},  32'(inst_bus.instDest), 32'd0);
        check({tag, "_src1"},  32'(inst_bus.instSrc1), 32'd0);
        check({tag, "_src2"},  32'(inst_bus.instSrc2), 32'd0);
        check({tag, "_flags"}, {28'd0, busy, halted, illegal, timeout}, 32'd0);
    endtask

    task automatic check_fields(input string tag, input logic [1:0] unit, input logic a1s0,
                                input logic [7:0] d, input logic [7:0] s1, input logic [7:0] s2);
        check({tag, "_unit"}, 32'(inst_bus.instUnit), 32'(unit));
        check({tag, "_as"},   32'(inst_bus.add1sub0), 32'(a1s0));
        check({tag, "_dest"}, 32'(inst_bus.instDest), 32'(d));
        check({tag, "_src1"}, 32'(inst_bus.instSrc1), 32'(s1));
        check({tag, "_src2"}, 32'(inst_bus.instSrc2), 32'(s2));
    endtask

    // Waits for an instruction, stalls it 5 cycles, then accepts it.
    task automatic expect_inst(input string tag, input logic [1:0] unit, input logic a1s0,
                               input logic [7:0] d, input logic [7:0] s1, input logic [7:0] s2);
        int n;
        n = 0;
        while (!inst_bus.instValid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(inst_bus.instValid), 32'd1);
        repeat (5) begin
            check_fields(tag, unit, a1s0, d, s1, s2);
            tick();
        end
        check({tag, "_stall_valid"}, 32'(inst_bus.instValid), 32'd1);
        check_fields({tag, "_stall"}, unit, a1s0, d, s1, s2);
        inst_bus.instReady = 1'b1;
        tick();
        inst_bus.instReady = 1'b0;
        check({tag, "_drop"}, 32'(inst_bus.instValid), 32'd0);
    endtask

    task automatic wait_halt(input string tag);
        int n;
        n = 0;
        while (!halted && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    initial begin
        int idx;
        logic [1:0] exp_unit [4];
        exp_unit[0] = 2'd0;
        exp_unit[1] = 2'd0;
        exp_unit[2] = 2'd1;
        exp_unit[3] = 2'd2;

        RESET = 1'b1;
        start = 1'b0;
        inst_bus.instReady = 1'b0;
        mem_bus.opFleg     = 1'b0;
        mem_bus.fromOpBus  = 32'd0;
        for (int i = 0; i < 16; i++) prog[i] = 32'hFF00_0000;
        mem_on = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
        check_reset("rst");
        tick();
        check("idle_no_en", 32'(mem_bus.opEN), 32'd0);

        $display("[TB] single add then STOP");
        prog[0] = 32'h0010_0102;
        prog[1] = 32'hFF00_0000;
        inst_bus.instReady = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_c1_en", 32'(mem_bus.opEN), 32'd1);
        check("t1_c1_busy", 32'(busy), 32'd1);
        tick();
        check("t1_c2_en", 32'(mem_bus.opEN), 32'd0);
        check("t1_c2_valid", 32'(inst_bus.instValid), 32'd0);
        tick();
        check("t1_c3_valid", 32'(inst_bus.instValid), 32'd1);
        check_fields("t1", 2'd0, 1'b1, 8'h10, 8'h01, 8'h02);
        tick();
        check("t1_c4_valid", 32'(inst_bus.instValid), 32'd0);
        check("t1_c4_en", 32'(mem_bus.opEN), 32'd1);
        check("t1_c4_cnt", 32'(mem_bus.opCounter), 32'd1);
        tick();
        tick();
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_cnt", 32'(mem_bus.opCounter), 32'd1);
        check("t1_halt_valid", 32'(inst_bus.instValid), 32'd0);
        check("t1_halt_busy", 32'(busy), 32'd0);

        $display("[TB] sub / mult / transpose with stalls");
        prog[0] = 32'h0120_2122;
        prog[1] = 32'h1030_3132;
        prog[2] = 32'h2040_4142;
        prog[3] = 32'hFF00_0000;
        inst_bus.instReady = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_inst("t2_sub",  2'd0, 1'b0, 8'h20, 8'h21, 8'h22);
        expect_inst("t2_mult", 2'd1, 1'b0, 8'h30, 8'h31, 8'h32);
        expect_inst("t2_tran", 2'd2, 1'b0, 8'h40, 8'h41, 8'h42);
        wait_halt("t2");
        check("t2_cnt", 32'(mem_bus.opCounter), 32'd3);

        $display("[TB] illegal opcode");
        prog[0] = 32'h4200_0000;
        inst_bus.instReady = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_c1_en", 32'(mem_bus.opEN), 32'd1);
        check("t3_c1_cnt", 32'(mem_bus.opCounter), 32'd0);
        tick();
        check("t3_c2_valid", 32'(inst_bus.instValid), 32'd0);
        tick();
        check("t3_c3_valid", 32'(inst_bus.instValid), 32'd0);
        check("t3_illegal", 32'(illegal), 32'd1);
        check("t3_halted", 32'(halted), 32'd1);
        prog[0] = 32'h0055_6677;
        prog[1] = 32'hFF00_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_rs_illegal", 32'(illegal), 32'd0);
        check("t3_rs_halted", 32'(halted), 32'd0);
        check("t3_rs_cnt", 32'(mem_bus.opCounter), 32'd0);
        check("t3_rs_en", 32'(mem_bus.opEN), 32'd1);
        tick();
        tick();
        check("t3_rs_valid", 32'(inst_bus.instValid), 32'd1);
        check_fields("t3_rs", 2'd0, 1'b1, 8'h55, 8'h66, 8'h77);
        wait_halt("t3_rs");

        $display("[TB] memory timeout");
        mem_on = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        check("t4_c17_busy", 32'(busy), 32'd1);
        check("t4_c17_timeout", 32'(timeout), 32'd0);
        tick();
        check("t4_timeout", 32'(timeout), 32'd1);
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_valid", 32'(inst_bus.instValid), 32'd0);
        mem_on = 1'b1;

        $display("[TB] full memory without STOP");
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: prog[i] = {8'h00, 8'(8'h80 + i), 8'(8'h40 + i), 8'(8'h20 + i)};
                1: prog[i] = {8'h01, 8'(8'h80 + i), 8'(8'h40 + i), 8'(8'h20 + i)};
                2: prog[i] = {8'h10, 8'(8'h80 + i), 8'(8'h40 + i), 8'(8'h20 + i)};
                default: prog[i] = {8'h20, 8'(8'h80 + i), 8'(8'h40 + i), 8'(8'h20 + i)};
            endcase
        end
        inst_bus.instReady = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_timeout_clr", 32'(timeout), 32'd0);
        idx = 0;
        for (int n = 0; n < 100 && !halted; n++) begin
            if (inst_bus.instValid) begin
                check("t5_dest", 32'(inst_bus.instDest), 32'(8'h80 + idx));
                check("t5_unit", 32'(inst_bus.instUnit), 32'(exp_unit[idx % 4]));
                idx++;
            end
            tick();
        end
        check("t5_count", 32'(idx), 32'd16);
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_cnt", 32'(mem_bus.opCounter), 32'd15);
        repeat (3) tick();
        check("t5_cnt_hold", 32'(mem_bus.opCounter), 32'd15);
        check("t5_no_valid", 32'(inst_bus.instValid), 32'd0);

        $display("[TB] reset during WAIT with opFleg");
        prog[0] = 32'h0011_2233;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_reset("t6");
        tick();
        check("t6_after_valid", 32'(inst_bus.instValid), 32'd0);
        check("t6_after_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
